// File: rtl/as512_bus_arbiter.sv
// Two-master burst sequencer for the AS512 16-bit multiplexed external memory bus.
// Skips the high-address latch phase while the upper address half matches the last one latched.
module as512_bus_arbiter #(
    parameter int LEN_W      = 6,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_req,
    input  logic [31:0]      m0_addr,
    input  logic             m0_we,
    input  logic             m0_dec,
    input  logic [LEN_W-1:0] m0_len,
    input  logic [15:0]      m0_wdata,
    output logic             m0_gnt,
    output logic             m0_wack,
    output logic [15:0]      m0_rdata,
    output logic             m0_rvalid,
    output logic             m0_done,
    input  logic             m1_req,
    input  logic [31:0]      m1_addr,
    input  logic             m1_we,
    input  logic             m1_dec,
    input  logic [LEN_W-1:0] m1_len,
    input  logic [15:0]      m1_wdata,
    output logic             m1_gnt,
    output logic             m1_wack,
    output logic [15:0]      m1_rdata,
    output logic             m1_rvalid,
    output logic             m1_done,
    input  logic [15:0]      data_in,
    output logic [15:0]      data_out,
    output logic             LEN2,
    output logic             LEN1,
    output logic             OPREQ,
    output logic             RW
);

    typedef enum logic [2:0] {S_IDLE, S_AHI, S_ALO, S_OP, S_DATA} state_t;

    state_t           r_state;
    logic             r_owner;
    logic             r_last_grant;
    logic             r_we;
    logic             r_dec;
    logic             r_hi_valid;
    logic [31:0]      r_addr;
    logic [LEN_W-1:0] r_cnt;
    logic [15:0]      r_last_hi;
    logic [1:0]       r_gnt;
    logic [1:0]       r_wack;
    logic [1:0]       r_rvalid;
    logic [1:0]       r_done;
    logic [15:0]      r_rdata;
    logic [15:0]      r_data_out;
    logic             r_len2;
    logic             r_len1;
    logic             r_opreq;
    logic             r_rw;

    logic             w_pick;
    logic [31:0]      w_req_addr;
    logic [31:0]      w_next_addr;
    logic [15:0]      w_wdata;

    assign w_pick      = (m0_req && m1_req) ? ((FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant) : m1_req;
    assign w_req_addr  = w_pick ? m1_addr : m0_addr;
    assign w_next_addr = r_dec ? (r_addr - 32'd1) : (r_addr + 32'd1);
    assign w_wdata     = r_owner ? m1_wdata : m0_wdata;

    // Outputs are loaded on the edge that enters a state; pulses default low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_dec        <= 1'b0;
            r_hi_valid   <= 1'b0;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_last_hi    <= '0;
            r_gnt        <= '0;
            r_wack       <= '0;
            r_rvalid     <= '0;
            r_done       <= '0;
            r_rdata      <= '0;
            r_data_out   <= '0;
            r_len2       <= 1'b0;
            r_len1       <= 1'b0;
            r_opreq      <= 1'b0;
            r_rw         <= 1'b0;
        end else begin
            r_wack     <= '0;
            r_rvalid   <= '0;
            r_done     <= '0;
            r_len2     <= 1'b0;
            r_len1     <= 1'b0;
            r_opreq    <= 1'b0;
            r_rw       <= 1'b0;
            r_data_out <= '0;
            case (r_state)
                S_IDLE: begin
                    // The done cycle is never an arbitration cycle: the finishing master's req is still up.
                    if (r_done == 2'b00 && (m0_req || m1_req)) begin
                        r_owner <= w_pick;
                        r_addr  <= w_req_addr;
                        r_we    <= w_pick ? m1_we  : m0_we;
                        r_dec   <= w_pick ? m1_dec : m0_dec;
                        r_cnt   <= w_pick ? m1_len : m0_len;
                        r_gnt   <= w_pick ? 2'b10 : 2'b01;
                        if (!r_hi_valid || w_req_addr[31:16] != r_last_hi) begin
                            r_state    <= S_AHI;
                            r_len2     <= 1'b1;
                            r_data_out <= w_req_addr[31:16];
                            r_last_hi  <= w_req_addr[31:16];
                            r_hi_valid <= 1'b1;
                        end else begin
                            r_state    <= S_ALO;
                            r_len1     <= 1'b1;
                            r_data_out <= w_req_addr[15:0];
                        end
                    end
                end
                S_AHI: begin
                    r_state    <= S_ALO;
                    r_len1     <= 1'b1;
                    r_data_out <= r_addr[15:0];
                end
                S_ALO: begin
                    r_state <= S_OP;
                    r_opreq <= 1'b1;
                    r_rw    <= r_we;
                    if (r_we) begin
                        r_data_out      <= w_wdata;
                        r_wack[r_owner] <= 1'b1;
                    end
                end
                S_OP: begin
                    r_state <= S_DATA;
                end
                S_DATA: begin
                    if (!r_we) begin
                        r_rdata           <= data_in;
                        r_rvalid[r_owner] <= 1'b1;
                    end
                    if (r_cnt == '0) begin
                        r_state         <= S_IDLE;
                        r_gnt           <= '0;
                        r_done[r_owner] <= 1'b1;
                        r_last_grant    <= r_owner;
                    end else begin
                        r_cnt  <= r_cnt - LEN_W'(1);
                        r_addr <= w_next_addr;
                        if (w_next_addr[31:16] != r_last_hi) begin
                            r_state    <= S_AHI;
                            r_len2     <= 1'b1;
                            r_data_out <= w_next_addr[31:16];
                            r_last_hi  <= w_next_addr[31:16];
                        end else begin
                            r_state    <= S_ALO;
                            r_len1     <= 1'b1;
                            r_data_out <= w_next_addr[15:0];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m0_gnt    = r_gnt[0];
    assign m1_gnt    = r_gnt[1];
    assign m0_wack   = r_wack[0];
    assign m1_wack   = r_wack[1];
    assign m0_rvalid = r_rvalid[0];
    assign m1_rvalid = r_rvalid[1];
    assign m0_done   = r_done[0];
    assign m1_done   = r_done[1];
    assign m0_rdata  = r_rdata;
    assign m1_rdata  = r_rdata;
    assign data_out  = r_data_out;
    assign LEN2      = r_len2;
    assign LEN1      = r_len1;
    assign OPREQ     = r_opreq;
    assign RW        = r_rw;

endmodule
